// File: rtl/ddpuf_pkg.sv
// ddpuf_pkg: shared constants and types for the DD-PUF SPI register block.
//   - Register addresses (CTRL, STATUS, DUR_BASE) and a helper that derives PUF_BASE.
//   - Bit positions inside CTRL and STATUS.
//   - SPI front-end state encoding.
package ddpuf_pkg;

    localparam int unsigned ADDR_W      = 7;

    localparam int unsigned CTRL_ADDR   = 0;
    localparam int unsigned STATUS_ADDR = 1;
    localparam int unsigned DUR_BASE    = 2;

    localparam int unsigned CTRL_START_BIT    = 0;
    localparam int unsigned CTRL_CLR_DONE_BIT = 1;
    localparam int unsigned STAT_BUSY_BIT     = 0;
    localparam int unsigned STAT_DONE_BIT     = 1;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWr,
        StRd
    } spi_state_e;

    // PUF bytes follow directly after the duration bytes.
    function automatic int unsigned puf_base(input int unsigned ndb);
        return DUR_BASE + ndb;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rising/falling edge detect.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   dout       : synchronised level (last synchroniser stage)
//   rise, fall : one-cycle pulses when dout changes 0->1 / 1->0
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // Bit STAGES is a history copy of dout, so edges never look at a metastable stage.
    logic [STAGES:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {(STAGES + 1){RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-1:0], din};
        end
    end

    assign dout = chain_q[STAGES-1];
    assign rise = chain_q[STAGES-1] & ~chain_q[STAGES];
    assign fall = ~chain_q[STAGES-1] & chain_q[STAGES];

endmodule

// File: rtl/ddpuf_spi_regs.sv
// ddpuf_spi_regs: oversampled SPI (mode 0) slave with a byte-addressed register file
// for the DD-PUF controller.
//   CLK, RST_N          : system clock, asynchronous active-low reset
//   SCLK, SS_N, MOSI    : SPI inputs, asynchronous to CLK
//   MISO, MISO_OE       : SPI data out and pad output enable
//   FSM_Start, Duration : start pulse and frozen duration to the measurement FSM
//   FSM_Complete, PUF_Val : completion pulse and PUF response from the measurement FSM
module ddpuf_spi_regs
    import ddpuf_pkg::*;
#(
    parameter int unsigned DUR_W       = 16,
    parameter int unsigned PUF_W       = 128,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SCLK,
    input  logic             SS_N,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_OE,
    output logic             FSM_Start,
    output logic [DUR_W-1:0] Duration,
    input  logic             FSM_Complete,
    input  logic [PUF_W-1:0] PUF_Val
);

    localparam int unsigned NDB      = DUR_W / 8;
    localparam int unsigned NPB      = PUF_W / 8;
    localparam int unsigned PUF_BASE = puf_base(NDB);
    localparam int unsigned NREG     = PUF_BASE + NPB;

    // ---------------- input synchronisation ----------------
    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic ss_n_s, ss_fall, ss_rise_unused;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk  (CLK),
        .rst_n(RST_N),
        .din  (SCLK),
        .dout (sclk_level_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Reset value 0 means a select already low at reset release produces no falling
    // edge, so the block waits for SS_N to go high before accepting a frame.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ss_sync (
        .clk  (CLK),
        .rst_n(RST_N),
        .din  (SS_N),
        .dout (ss_n_s),
        .rise (ss_rise_unused),
        .fall (ss_fall)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ---------------- frame FSM ----------------
    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic [7:0] rx_byte;
    logic [ADDR_W-1:0] addr_q, rd_addr;
    logic active, bit_rise, byte_done, wr_en, rd_load, tx_shift;

    assign rx_byte = {shift_q, mosi_s};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_n_s) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (ss_fall) state_d = StCmd;
                StCmd:   if (byte_done) state_d = rx_byte[7] ? StRd : StWr;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        active    = (state_q != StIdle) && !ss_n_s;
        bit_rise  = active && sclk_rise;
        byte_done = bit_rise && (bit_cnt_q == 3'd7);
        wr_en     = byte_done && (state_q == StWr);
        rd_load   = byte_done && ((state_q == StCmd && rx_byte[7]) || state_q == StRd);
        tx_shift  = active && sclk_fall && (state_q == StRd);
        // The command byte supplies the first read address directly.
        rd_addr   = (state_q == StCmd) ? rx_byte[6:0] : addr_q;
    end

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (32'(a) == NREG - 1) return '0;
        return a + 7'd1;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
        end else begin
            if (!active) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (bit_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= rx_byte[6:0];
            end
            // Write frames hold the current target; read frames hold the next byte to load.
            if (byte_done) begin
                if (state_q == StCmd) addr_q <= rx_byte[7] ? addr_inc(rx_byte[6:0]) : rx_byte[6:0];
                else                  addr_q <= addr_inc(addr_q);
            end
        end
    end

    // ---------------- register file ----------------
    logic [DUR_W-1:0] dur_q;
    logic [PUF_W-1:0] puf_q;
    logic busy_q, done_q;
    logic ctrl_wr, start_ok, complete, clr_done;
    logic [7:0] rd_data;
    int unsigned wr_idx, rd_idx;

    always_comb begin
        wr_idx   = 32'(addr_q);
        ctrl_wr  = wr_en && (wr_idx == CTRL_ADDR);
        // START is judged against pre-cycle BUSY, so a same-cycle completion cannot
        // let it through.
        start_ok = ctrl_wr && rx_byte[CTRL_START_BIT] && !busy_q;
        clr_done = ctrl_wr && rx_byte[CTRL_CLR_DONE_BIT];
        complete = FSM_Complete && busy_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dur_q     <= '0;
            puf_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            FSM_Start <= 1'b0;
            Duration  <= '0;
        end else begin
            if (wr_en) begin
                for (int unsigned i = 0; i < NDB; i++) begin
                    if (wr_idx == DUR_BASE + i) dur_q[DUR_W-1-8*i -: 8] <= rx_byte;
                end
            end
            if (complete) puf_q <= PUF_Val;

            FSM_Start <= start_ok;
            if (start_ok) Duration <= dur_q;

            if (start_ok)      busy_q <= 1'b1;
            else if (complete) busy_q <= 1'b0;

            if (complete)                  done_q <= 1'b1;
            else if (start_ok || clr_done) done_q <= 1'b0;
        end
    end

    always_comb begin
        rd_idx  = 32'(rd_addr);
        rd_data = 8'h00;
        if (rd_idx == STATUS_ADDR) begin
            rd_data[STAT_BUSY_BIT] = busy_q;
            rd_data[STAT_DONE_BIT] = done_q;
        end
        for (int unsigned i = 0; i < NDB; i++) begin
            if (rd_idx == DUR_BASE + i) rd_data = dur_q[DUR_W-1-8*i -: 8];
        end
        for (int unsigned i = 0; i < NPB; i++) begin
            if (rd_idx == PUF_BASE + i) rd_data = puf_q[PUF_W-1-8*i -: 8];
        end
    end

    // ---------------- read shifter ----------------
    logic [7:0] tx_q;
    logic miso_q, oe_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
        end else if (ss_n_s) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            if (rd_load)       tx_q <= rd_data;
            else if (tx_shift) tx_q <= {tx_q[6:0], 1'b0};
            if (tx_shift) begin
                miso_q <= tx_q[7];
                oe_q   <= 1'b1;
            end
        end
    end

    assign MISO    = miso_q;
    assign MISO_OE = oe_q;

endmodule
